reg_bank_32: RTL
================

# reg_bank_32

Register bank for the single-cycle MIPS datapath; the write-side consumer of the register-destination select and the read-side producer of the ALU operand select path. It decodes the 5-bit write address into per-register write enables, which is the demultiplexing counterpart of the datapath's select logic. It stores 32 words of 32 bits and provides two combinational read ports. Register 0 is hardwired to zero.

## Interface
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 5, width of register addresses; the bank depth is 2^ADDR_W
- BYPASS, 1, 1 = a read of the register being written this cycle returns WriteData; 0 = it returns the stored value

- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock
- RegWrite  input  1  write enable from Control
- WriteRegister  input  ADDR_W  destination address from the register-destination select
- WriteData  input  DATA_W  write-back value
- ReadRegister1  input  ADDR_W  source address, port 1 (rs)
- ReadRegister2  input  ADDR_W  source address, port 2 (rt)
- ReadData1  output  DATA_W  port 1 data
- ReadData2  output  DATA_W  port 2 data

## Operation
- Storage: registers r0..r(2^ADDR_W-1), each DATA_W bits.
- Write decode: the one-hot enable is en[i] = RegWrite & (WriteRegister == i) & (i != 0). At most one register updates per cycle.
- Write: on a rising edge with reset high and en[i] set, r[i] <= WriteData.
- r0 always reads 0. Writes to r0 are discarded with no side effect.
- Reads are purely combinational from the address inputs and the stored state.
  - ReadDataN = 0 when ReadRegisterN == 0.
  - Otherwise, if BYPASS = 1, RegWrite = 1 and ReadRegisterN == WriteRegister, ReadDataN = WriteData.
  - Otherwise, ReadDataN = r[ReadRegisterN].
- Both read ports may address the same register. Each port resolves independently.
- Reset: on a rising edge with reset low, every register is cleared to 0.
  - Reset takes priority over any simultaneous write; the write is lost.
- Reset value of outputs: ReadData1 = ReadData2 = 0 from the first edge with reset low, for any address.
  - While reset stays low and BYPASS = 1, a matching RegWrite still bypasses WriteData combinationally.
  - The bypassed value is not stored.
- Reset deasserted mid-sequence: the first edge with reset high performs a normal write.
- Unknown (X) addresses or enables do not need defined behaviour. The bench drives known values only.

## Timing
- Write latency: 1 clock. Data presented with RegWrite before edge k is visible from stored state after edge k.
- Read latency: 0 clocks (combinational).
  - With BYPASS = 0, a same-cycle read of the target register returns the old value until after the edge.
- No handshake. RegWrite is a single-cycle qualifier and back-to-back writes every cycle are legal.
- Back-to-back writes to the same register: the last write wins, one per edge.
- The combinational read path must meet the single-cycle datapath budget. Decode is one 5-to-32 decoder on the write side and 32:1 selection on each read port.

## Test plan
- Reset: hold reset low for 2 edges after writing 0xDEADBEEF to r5, then release. Read r5 on both ports -> 0x00000000.
- Basic write/read: write 0x12345678 to r8 and 0xCAFEF00D to r31 on consecutive edges. Read r8 on port 1 and r31 on port 2 -> 0x12345678 and 0xCAFEF00D.
- r0 protection: RegWrite = 1, WriteRegister = 0, WriteData = 0xFFFFFFFF, then read r0 on both ports -> 0x00000000.
  - Same cycle, the BYPASS = 1 read of r0 -> 0.
- Bypass: with BYPASS = 1, r9 = 0x1 stored, drive a write of 0x2 to r9 and read r9 on both ports in the same cycle -> 0x2 before the edge.
  - Repeat with BYPASS = 0 -> 0x1 before the edge, 0x2 after it.
- RegWrite low: WriteRegister = 3 and WriteData = 0xAAAA5555 with RegWrite = 0 for 3 edges. Read r3 -> its prior value, unchanged.
- Reset/write collision: reset low and RegWrite = 1 to r12 with 0x77 on the same edge. Read r12 after release -> 0x00000000.
  - The next edge with reset high writes 0x77 -> r12 reads 0x77.

Source files
------------

// File: rtl/reg_bank_32.sv
// reg_bank_32: 2^ADDR_W x DATA_W register file, r0 hardwired to zero.
// One write port with a one-hot decoder, two combinational read ports with optional bypass.
module reg_bank_32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  w_wen;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_zero1;
    logic              w_zero2;

    always_comb begin
        w_wen = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_wen[i] = RegWrite && (WriteRegister == ADDR_W'(i));
        end
    end

    // r0 is kept cleared so the storage never holds anything but zero there
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs[0] <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                if (w_wen[i]) begin
                    r_regs[i] <= WriteData;
                end
            end
        end
    end

    assign w_zero1 = (ReadRegister1 == '0);
    assign w_zero2 = (ReadRegister2 == '0);
    assign w_hit1  = BYP && RegWrite && (ReadRegister1 == WriteRegister);
    assign w_hit2  = BYP && RegWrite && (ReadRegister2 == WriteRegister);

    always_comb begin
        ReadData1 = r_regs[ReadRegister1];
        if (w_zero1) begin
            ReadData1 = '0;
        end else if (w_hit1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = r_regs[ReadRegister2];
        if (w_zero2) begin
            ReadData2 = '0;
        end else if (w_hit2) begin
            ReadData2 = WriteData;
        end
    end

endmodule
